// File: rtl/pixel_pkg.sv
// Pixel types shared by ntsc_capture / pixel_lpf / projective_transform,
// plus the [1 2 1]/4 horizontal kernel applied per 6-bit channel.
package pixel_pkg;
    localparam int CHAN_W   = 6;
    localparam int NUM_CHAN = 3;
    localparam int PIX_W    = CHAN_W * NUM_CHAN;
    localparam int LINE_W   = 640;
    localparam int LINE_H   = 480;

    typedef logic [CHAN_W-1:0] chan_t;
    typedef logic [PIX_W-1:0]  pixel_t;

    typedef enum logic [1:0] {WIN_EMPTY, WIN_ONE, WIN_RUN} win_state_e;

    // Max sum is 63+126+63+2 = 254, so 8 bits never wrap and no clamp is needed.
    function automatic chan_t lpf_tap(input chan_t l, input chan_t c, input chan_t r);
        logic [7:0] sum;
        sum = {2'b00, l} + {1'b0, c, 1'b0} + {2'b00, r} + 8'd2;
        return sum[7:2];
    endfunction

    function automatic pixel_t lpf_pix(input pixel_t l, input pixel_t c, input pixel_t r);
        pixel_t o;
        for (int i = 0; i < NUM_CHAN; i++)
            o[i*CHAN_W +: CHAN_W] = lpf_tap(l[i*CHAN_W +: CHAN_W], c[i*CHAN_W +: CHAN_W],
                                            r[i*CHAN_W +: CHAN_W]);
        return o;
    endfunction
endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with registered read data; a write while full is accepted
// only if a read frees a slot in the same cycle.
module pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 18
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_data,
    input  logic                   rd_en,
    output logic [W-1:0]           rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, rptr_q;
    logic [W-1:0] rd_data_q;
    logic         do_wr, do_rd;

    assign level   = wptr_q - rptr_q;
    assign empty   = (level == '0);
    assign full    = level[AW];
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = rd_data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            rd_data_q <= '0;
        end else if (flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_rd) begin
                rptr_q    <= rptr_q + (AW+1)'(1);
                rd_data_q <= mem_q[rptr_q[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/pixel_lpf.sv
// Horizontal [1 2 1]/4 line filter feeding a request-driven pixel FIFO.
// Define PIXEL_LPF_DROP_CNT_EN to build the saturating overflow drop counter.
module pixel_lpf #(
    parameter int LINE_W     = pixel_pkg::LINE_W,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        frame_flag,
    input  logic [pixel_pkg::PIX_W-1:0] in_pixel,
    input  logic                        in_valid,
    input  logic                        request_pixel,
    output logic [pixel_pkg::PIX_W-1:0] pixel,
    output logic                        pixel_flag,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 drop_count
);
    import pixel_pkg::*;

    localparam int CW = $clog2(LINE_W);

    win_state_e    state_q;
    logic [CW-1:0] col_q;
    pixel_t        l_q, c_q, tail_l_q, tail_c_q, wr_data_q, win_res, rd_data;
    logic          tail_q, wr_en_q, pending_q, pending_d, flag_q;
    logic          last_col, rd_en, fifo_full, fifo_empty, drop;

    assign last_col = (col_q == CW'(LINE_W-1));
    assign win_res  = (state_q == WIN_ONE) ? lpf_pix(c_q, c_q, in_pixel)
                                           : lpf_pix(l_q, c_q, in_pixel);

    // Window: each accepted pixel emits the previous column; the line's last
    // column is emitted one cycle later from a private copy so column 0 of the
    // next line can load immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= WIN_EMPTY;
            col_q     <= '0;
            l_q       <= '0;
            c_q       <= '0;
            tail_l_q  <= '0;
            tail_c_q  <= '0;
            tail_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            tail_q  <= 1'b0;
            if (frame_flag) begin
                state_q <= in_valid ? WIN_ONE : WIN_EMPTY;
                col_q   <= in_valid ? CW'(1) : '0;
                if (in_valid) c_q <= in_pixel;
            end else begin
                if (tail_q) begin
                    wr_en_q   <= 1'b1;
                    wr_data_q <= lpf_pix(tail_l_q, tail_c_q, tail_c_q);
                end
                if (in_valid) begin
                    col_q <= last_col ? '0 : col_q + CW'(1);
                    l_q   <= c_q;
                    c_q   <= in_pixel;
                    case (state_q)
                        WIN_EMPTY: state_q <= WIN_ONE;
                        default: begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= win_res;
                            state_q   <= last_col ? WIN_EMPTY : WIN_RUN;
                            if (last_col) begin
                                tail_q   <= 1'b1;
                                tail_l_q <= c_q;
                                tail_c_q <= in_pixel;
                            end
                        end
                    endcase
                end
            end
        end
    end

    pixel_fifo #(.DEPTH(FIFO_DEPTH), .W(PIX_W)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (frame_flag),
        .wr_en   (wr_en_q),
        .wr_data (wr_data_q),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // A request against an empty FIFO collapses into one pending bit.
    assign rd_en     = ~frame_flag & (request_pixel | pending_q) & ~fifo_empty;
    assign pending_d = (frame_flag | rd_en) ? 1'b0
                     : (request_pixel & fifo_empty) ? 1'b1 : pending_q;
    assign drop      = wr_en_q & fifo_full & ~rd_en & ~frame_flag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= 1'b0;
            flag_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            flag_q    <= rd_en;
        end
    end

    assign pixel      = rd_data;
    assign pixel_flag = flag_q;

`ifdef PIXEL_LPF_DROP_CNT_EN
    logic [15:0] drop_q, drop_d;
    always_comb begin
        drop_d = drop_q;
        if (frame_flag)                     drop_d = '0;
        else if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) drop_q <= '0;
        else          drop_q <= drop_d;
    end
    assign drop_count = drop_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign drop_count  = '0;
`endif
endmodule

// File: tb/tb_pixel_lpf.sv
// Directed bench for pixel_lpf: a line-buffer/queue model checked every cycle,
// plus literal expectations for the filter values and handshake timing.
module tb_pixel_lpf;
    localparam int LW = 640;
    localparam int FD = 16;

    logic        clk = 1'b0, reset_n = 1'b0, frame_flag = 1'b0;
    logic        in_valid = 1'b0, request_pixel = 1'b0;
    logic [17:0] in_pixel = '0;
    logic [17:0] pixel;
    logic        pixel_flag;
    logic [4:0]  fifo_level;
    logic [15:0] drop_count;

    int total = 0, bad = 0;
    bit chk_en = 0;

    pixel_lpf #(.LINE_W(LW), .FIFO_DEPTH(FD)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .frame_flag    (frame_flag),
        .in_pixel      (in_pixel),
        .in_valid      (in_valid),
        .request_pixel (request_pixel),
        .pixel         (pixel),
        .pixel_flag    (pixel_flag),
        .fifo_level    (fifo_level),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int t; logic [17:0] d; } wr_t;
    logic [17:0] line_buf [LW];
    wr_t         sched[$];
    logic [17:0] mq[$];
    int          col = 0, pcyc = 0, mdrops = 0;
    bit          pend = 0, mflag = 0;
    logic [17:0] mpix = '0;

    function automatic logic [5:0] tap(input int l, input int c, input int r);
        return 6'((l + 2*c + r + 2) / 4);
    endfunction

    function automatic logic [17:0] filt(input int j);
        logic [17:0] l, c, r, o;
        c = line_buf[j];
        l = (j == 0)    ? c : line_buf[j-1];
        r = (j == LW-1) ? c : line_buf[j+1];
        for (int i = 0; i < 3; i++)
            o[i*6 +: 6] = tap(int'(l[i*6 +: 6]), int'(c[i*6 +: 6]), int'(r[i*6 +: 6]));
        return o;
    endfunction

    always @(posedge clk) begin : model
        bit          due, empty, rd;
        logic [17:0] dd;
        wr_t         w;
        pcyc++;
        if (!reset_n) begin
            sched.delete(); mq.delete();
            col = 0; pend = 0; mflag = 0; mpix = '0; mdrops = 0;
        end else begin
            due = (sched.size() > 0 && sched[0].t == pcyc);
            dd  = '0;
            if (due) begin dd = sched[0].d; void'(sched.pop_front()); end
            if (frame_flag) begin
                mflag = 0; pend = 0; mdrops = 0; col = 0;
                mq.delete(); sched.delete();
            end else begin
                empty = (mq.size() == 0);
                rd    = (request_pixel || pend) && !empty;
                mflag = rd;
                if (rd) begin mpix = mq.pop_front(); pend = 0; end
                else if (request_pixel && empty) pend = 1;
                if (due) begin
                    if (mq.size() < FD) mq.push_back(dd);
                    else if (mdrops < 65535) mdrops++;
                end
            end
            if (in_valid) begin
                line_buf[col] = in_pixel;
                if (col >= 1) begin w.t = pcyc + 1; w.d = filt(col - 1); sched.push_back(w); end
                if (col == LW-1) begin
                    w.t = pcyc + 2; w.d = filt(col); sched.push_back(w);
                    col = 0;
                end else col++;
            end
        end
    end

    function automatic int exp_drops();
`ifdef PIXEL_LPF_DROP_CNT_EN
        return mdrops;
`else
        return 0;
`endif
    endfunction

    // ---------------- per-cycle compare ----------------
    logic [17:0] got[$];
    int          nflags = 0;

    always @(negedge clk) begin
        if (reset_n && chk_en) begin
            check("pixel_flag", 32'(pixel_flag), 32'(mflag));
            check("pixel", 32'(pixel), 32'(mpix));
            check("fifo_level", 32'(fifo_level), mq.size());
            check("drop_count", 32'(drop_count), exp_drops());
        end
        if (reset_n && pixel_flag === 1'b1) begin
            got.push_back(pixel);
            nflags++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic idle(input int n);
        in_valid = 0; frame_flag = 0;
        repeat (n) tick();
    endtask

    task automatic push(input logic [17:0] p);
        in_valid = 1; in_pixel = p;
        tick();
        in_valid = 0;
    endtask

    task automatic flush_pulse();
        frame_flag = 1; tick(); frame_flag = 0;
    endtask

    function automatic int stepv(input int k);
        if (k < 2)   return 0;
        if (k < 637) return 40;
        if (k == 637) return 16;
        if (k == 638) return 8;
        return 60;
    endfunction

    int          base, nb, cw, cf, nf, okc;
    logic [17:0] g;

    initial begin
        repeat (3) tick();
        check("reset pixel", 32'(pixel), 0);
        check("reset pixel_flag", 32'(pixel_flag), 0);
        check("reset fifo_level", 32'(fifo_level), 0);
        check("reset drop_count", 32'(drop_count), 0);
        reset_n = 1; chk_en = 1;
        tick();

        // Constant line then a step line back-to-back, consumed as produced.
        request_pixel = 1;
        for (int k = 0; k < LW; k++) push(18'h15555);
        for (int k = 0; k < LW; k++) push({12'd0, 6'(stepv(k))});
        idle(10);
        check("line pulse count", nflags, 2*LW);
        okc = 0;
        for (int i = 0; i < LW; i++) begin g = got[i]; if (g == 18'h15555) okc++; end
        check("constant line values", okc, LW);
        g = got[LW];   check("step col0", 32'(g[5:0]), 0);
        g = got[LW+1]; check("step col1", 32'(g[5:0]), 10);
        g = got[LW+2]; check("step col2", 32'(g[5:0]), 30);
        g = got[LW+3]; check("step col3", 32'(g[5:0]), 40);
        g = got[2*LW-2]; check("edge col638", 32'(g[5:0]), 23);
        g = got[2*LW-1]; check("edge col639", 32'(g[5:0]), 47);

        // Overflow: 19 filtered pixels into a 16-deep FIFO, then drain.
        request_pixel = 0;
        flush_pulse();
        for (int k = 0; k < 20; k++) push({12'd0, 6'(3*k)});
        idle(4);
        check("overflow level", 32'(fifo_level), 16);
`ifdef PIXEL_LPF_DROP_CNT_EN
        check("overflow drops", 32'(drop_count), 3);
`else
        check("overflow drops", 32'(drop_count), 0);
`endif
        base = got.size();
        request_pixel = 1;
        idle(20);
        request_pixel = 0;
        check("drain count", got.size() - base, 16);
        for (int i = 0; i < 16; i++) begin
            g = got[base+i];
            check("drain order", 32'(g[5:0]), (i == 0) ? 1 : 3*i);
        end

        // Pending request served two cycles after the write edge.
        flush_pulse();
        idle(1);
        request_pixel = 1; tick(); request_pixel = 0;
        idle(2);
        push({12'd0, 6'd33});
        push({12'd0, 6'd33});
        cw = -1; cf = -1; nf = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cw < 0 && fifo_level != 0) cw = i;
            if (pixel_flag) begin nf++; if (cf < 0) cf = i; end
        end
        check("pending flag count", nf, 1);
        check("pending latency", cf - cw, 1);
        g = got[got.size()-1];
        check("pending value", 32'(g[5:0]), 33);

        // Flush with 7 queued and a same-cycle pixel that becomes column 0.
        tick();
        flush_pulse();
        for (int k = 0; k < 8; k++) push({12'd0, 6'(k+1)});
        idle(3);
        check("queued level", 32'(fifo_level), 7);
        nb = nflags;
        frame_flag = 1; in_valid = 1; in_pixel = {12'd0, 6'd20}; request_pixel = 1;
        tick();
        frame_flag = 0; in_valid = 0; request_pixel = 0;
        check("flush level", 32'(fifo_level), 0);
        check("flush pixel_flag", 32'(pixel_flag), 0);
        idle(3);
        request_pixel = 1;
        push({12'd0, 6'd24});
        idle(5);
        request_pixel = 0;
        check("post-flush count", nflags - nb, 1);
        g = got[got.size()-1];
        check("post-flush col0", 32'(g[5:0]), 21);

        // Reset asserted while the line tail is in flight.
        flush_pulse();
        request_pixel = 1;
        for (int k = 0; k < LW; k++) push({6'(k), 6'(k >> 3), 6'(63 - (k % 64))});
        reset_n = 0;
        #1;
        check("midtail pixel", 32'(pixel), 0);
        check("midtail pixel_flag", 32'(pixel_flag), 0);
        check("midtail fifo_level", 32'(fifo_level), 0);
        check("midtail drop_count", 32'(drop_count), 0);
        tick(); tick();
        reset_n = 1;
        nb = nflags;
        idle(5);
        request_pixel = 0;
        check("post-reset flags", nflags - nb, 0);
        check("post-reset level", 32'(fifo_level), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
